// File: rtl/freq_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freq_meter_pkg
// Description : Shared state encoding for the frequency meter, visible to the
//               bench so it can decode the controller state.
// Revision    : 1.0 - initial release
// ============================================================================
package freq_meter_pkg;

  // Measurement controller states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

  // Width of a counter that must hold values 0..n-1 (never below one bit)
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_detect
// Description : Multi-flop synchroniser for an asynchronous input followed by
//               one edge register; flags a rising edge for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the asynchronous input through the synchroniser, then remember the
  // previous synchronised level for edge detection
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : freq_meter
// Description : Counts rising edges of an asynchronous signal over a fixed
//               gate window of clk_in cycles and publishes the count with a
//               one-cycle valid strobe. Windows run back-to-back while enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CLK_HZ      = 125000000,
  parameter int GATE_CYCLES = CLK_HZ,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic             overflow,
  output logic             measuring
);

  localparam int                 GATE_W      = cnt_width(GATE_CYCLES);
  localparam int                 ARM_W       = cnt_width(SYNC_STAGES + 1);
  localparam logic [GATE_W-1:0]  C_GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [ARM_W-1:0]   C_ARM_LAST  = ARM_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0]   C_CNT_MAX   = '1;

  state_t             r_state;
  logic [ARM_W-1:0]   r_arm_cnt;
  logic [GATE_W-1:0]  r_gate_cnt;
  logic [CNT_W-1:0]   r_edge_cnt;
  logic               r_sat;
  logic [CNT_W-1:0]   r_freq_out;
  logic               r_freq_valid;
  logic               r_overflow;
  logic               r_measuring;

  logic               w_rise;
  logic               w_gate_last;
  logic [CNT_W-1:0]   w_edge_next;
  logic               w_sat_next;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk_in   (clk_in),
    .rst      (rst),
    .async_in (sig_in),
    .rise     (w_rise)
  );

  assign w_gate_last = (r_gate_cnt == C_GATE_LAST);

  // Saturating edge count including this cycle's rise; an edge arriving
  // when the counter is already full is lost and flags saturation
  always_comb begin
    w_edge_next = r_edge_cnt;
    w_sat_next  = r_sat;
    if (w_rise) begin
      if (r_edge_cnt == C_CNT_MAX) begin
        w_sat_next = 1'b1;
      end else begin
        w_edge_next = r_edge_cnt + CNT_W'(1);
      end
    end
  end

  // Measurement controller: idle, arm (flush synchroniser), gated counting
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_arm_cnt    <= '0;
      r_gate_cnt   <= '0;
      r_edge_cnt   <= '0;
      r_sat        <= 1'b0;
      r_freq_out   <= '0;
      r_freq_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_measuring  <= 1'b0;
    end else begin
      r_freq_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_arm_cnt   <= '0;
          r_gate_cnt  <= '0;
          r_edge_cnt  <= '0;
          r_sat       <= 1'b0;
          r_measuring <= 1'b0;
          if (enable) begin
            r_state <= ST_ARM;
          end
        end
        ST_ARM: begin
          // Rises seen here are stale synchroniser contents and are ignored
          if (!enable) begin
            r_state   <= ST_IDLE;
            r_arm_cnt <= '0;
          end else if (r_arm_cnt == C_ARM_LAST) begin
            r_state     <= ST_MEASURE;
            r_arm_cnt   <= '0;
            r_gate_cnt  <= '0;
            r_edge_cnt  <= '0;
            r_sat       <= 1'b0;
            r_measuring <= 1'b1;
          end else begin
            r_arm_cnt <= r_arm_cnt + ARM_W'(1);
          end
        end
        ST_MEASURE: begin
          if (w_gate_last) begin
            // Window complete: publish even if enable dropped on this cycle
            r_freq_out   <= w_edge_next;
            r_overflow   <= w_sat_next;
            r_freq_valid <= 1'b1;
            r_gate_cnt   <= '0;
            r_edge_cnt   <= '0;
            r_sat        <= 1'b0;
            if (!enable) begin
              r_state     <= ST_IDLE;
              r_measuring <= 1'b0;
            end
          end else if (!enable) begin
            // Partial window is discarded
            r_state     <= ST_IDLE;
            r_measuring <= 1'b0;
            r_gate_cnt  <= '0;
            r_edge_cnt  <= '0;
            r_sat       <= 1'b0;
          end else begin
            r_gate_cnt <= r_gate_cnt + GATE_W'(1);
            r_edge_cnt <= w_edge_next;
            r_sat      <= w_sat_next;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_measuring <= 1'b0;
        end
      endcase
    end
  end

  assign freq_out   = r_freq_out;
  assign freq_valid = r_freq_valid;
  assign overflow   = r_overflow;
  assign measuring  = r_measuring;

endmodule
`default_nettype wire
